// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode/state enums and decode helper shared by seq_alu and seq_alu_comb
package seq_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_MUL = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Opcodes handled by the single-cycle datapath; MUL is decided by the top.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// rtl/seq_alu_comb.sv - combinational FWD/ADD/SUB/AND/OR datapath with signed overflow
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             legal_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sa;
  logic             sb;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign sa   = a_i[WIDTH-1];
  assign sb   = b_i[WIDTH-1];

  assign legal_o = is_alu_op(op_i);

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      OP_FWD: result_o = b_i;
      OP_ADD: begin
        result_o = sum;
        ovf_o    = (sa == sb) && (sum[WIDTH-1] != sa);
      end
      OP_SUB: begin
        result_o = diff;
        ovf_o    = (sa != sb) && (diff[WIDTH-1] != sa);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked registered ALU; SEQ_ALU_MUL_EN builds the WIDTH-cycle shift-add MUL
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_legal;

  logic             start_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;

  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (alu_result),
    .ovf_o    (alu_ovf),
    .legal_o  (alu_legal)
  );

`ifdef SEQ_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum;

  // Low WIDTH bits of an unsigned shift-add product equal the signed product's.
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign start_mul  = (op == OP_MUL);
  assign mul_done   = (cnt_q == CNT_W'(1));
  assign mul_result = acc_sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if ((state_q == S_IDLE) && in_valid && start_mul) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (state_q == S_MUL) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  assign start_mul  = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_result = '0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (start_mul) begin
            state_d = S_MUL;
          end else begin
            result_d    = alu_result;
            zero_d      = (alu_result == '0);
            ovf_d       = alu_ovf;
            err_d       = !alu_legal;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          result_d    = mul_result;
          zero_d      = (mul_result == '0);
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // Returning to IDLE first keeps accept out of the handshake cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - random plus directed bench for seq_alu against an arithmetic reference model
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         err;

  int tests = 0;
  int fails = 0;
  int nedge = 0;

  logic rdy_mode = 1'b0;
  logic rdy_val  = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         e;
    int           due;
  } exp_t;

  exp_t q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic ov, output logic er,
                                output int lat);
    int sx;
    int sy;
    int s;
    sx  = $signed(x);
    sy  = $signed(y);
    r   = '0;
    ov  = 1'b0;
    er  = 1'b0;
    lat = 1;
    case (o)
      3'd0: r = y;
      3'd1: begin s = sx + sy; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd2: begin s = sx - sy; r = W'(s); ov = (s > 127) || (s < -128); end
      3'd3: r = x & y;
      3'd4: r = x | y;
`ifdef SEQ_ALU_MUL_EN
      3'd5: begin s = sx * sy; r = W'(s); lat = W; end
`else
      3'd5: er = 1'b1;
`endif
      default: er = 1'b1;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {zero, ovf, err}, 0);
    end else begin
      chk("in_ready", in_ready, q.size() == 0);
      if (q.size() != 0 && nedge >= q[0].due) begin
        chk("out_valid", out_valid, 1);
        chk("result", result, q[0].res);
        chk("zero", zero, q[0].z);
        chk("ovf", ovf, q[0].o);
        chk("err", err, q[0].e);
        if (out_valid && out_ready) void'(q.pop_front());
      end else begin
        chk("out_valid_quiet", out_valid, 0);
      end
      if (in_valid && in_ready) begin
        model(op, a, b, e.res, e.o, e.e, lat);
        e.z   = (e.res == '0);
        e.due = nedge + lat;
        q.push_back(e);
      end
    end
    nedge++;
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = W'($urandom);
    b  = W'($urandom);
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    wait_accept();
  endtask

  task automatic directed(input string name, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                          input logic eo, input logic ee, input int elat);
    logic [W-1:0] mr;
    logic         mo;
    logic         me;
    int           ml;
    int           n;
    model(o, x, y, mr, mo, me, ml);
    chk({name, "_model_res"}, mr, er);
    chk({name, "_model_ovf"}, mo, eo);
    chk({name, "_model_err"}, me, ee);
    chk({name, "_model_lat"}, ml, elat);
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    issue(o, x, y);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_lat"}, n, elat);
    chk({name, "_res"}, result, er);
    chk({name, "_flags"}, {zero, ovf, err}, {ez, eo, ee});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic [W-1:0] corner [5];
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F; corner[3] = 8'h80; corner[4] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed("and_zero", 3'd3, 8'hD4, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    directed("add_ovf",  3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1);
    directed("sub_zero", 3'd2, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    directed("sub_ovf",  3'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1);
    directed("fwd",      3'd0, 8'h11, 8'h9C, 8'h9C, 1'b0, 1'b0, 1'b0, 1);
    directed("or",       3'd4, 8'h50, 8'h05, 8'h55, 1'b0, 1'b0, 1'b0, 1);
    directed("ill_110",  3'd6, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1);
`ifdef SEQ_ALU_MUL_EN
    directed("mul_pos",  3'd5, 8'd15, 8'd11, 8'hA5, 1'b0, 1'b0, 1'b0, 8);
    directed("mul_neg",  3'd5, 8'hFD, 8'd5,  8'hF1, 1'b0, 1'b0, 1'b0, 8);
`else
    directed("mul_off",  3'd5, 8'd15, 8'd11, 8'h00, 1'b1, 1'b0, 1'b1, 1);
`endif

    // Consumer stalls in DONE while the next operation waits on the input.
    rdy_mode = 1'b0;
    rdy_val  = 1'b0;
    issue(3'd1, 8'h40, 8'h40);
    in_valid = 1'b1;
    op = 3'd4;
    a  = 8'h0F;
    b  = 8'hF0;
    repeat (3) @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_result", result, 8'h80);
    chk("stall_flags", {out_valid, ovf}, 2'b11);
    rdy_val = 1'b1;
    wait_accept();
    repeat (3) @(posedge clk);

    // Reset four cycles into a long operation aborts it.
    rdy_val = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    issue(3'd5, 8'd15, 8'd11);
`else
    issue(3'd1, 8'd3, 8'd4);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result", result, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rdy_val = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 0);

    rdy_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      issue(ro, rx, ry);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU for the single-cycle processor datapath, generalising the 8-bit AND unit to WIDTH-bit operands and multiple operations. It registers every result and adds an optional multi-cycle shift-add multiplier, so it uses valid/ready handshakes on input and output. It sits between the register-file read ports and the write-back mux and stalls the core through in_ready.

## Interface
- WIDTH, 8: operand/result width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- op  input  3  opcode: 000 FWD (B), 001 ADD, 010 SUB (A-B), 011 AND, 100 OR, 101 MUL; others illegal.
- a, b  input  WIDTH  signed two's-complement operands.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow on ADD/SUB; 0 for all other ops.
- err  output  1  illegal opcode was issued.

## Operation
- FSM states: IDLE, MUL, DONE. Reset state is IDLE.
- in_ready = (state == IDLE), decoded combinationally, including while rst_n is low.
- Accept happens on an edge with in_valid && in_ready. Operands and op are captured only then; they are ignored at all other times.
- FWD, ADD, SUB, AND, OR, and illegal opcodes: at the accept edge, compute and register result, zero, ovf and err, then go IDLE -> DONE.
- Illegal opcode: result = 0, zero = 1, ovf = 0, err = 1.
- ADD and SUB wrap modulo 2^WIDTH.
- ovf for ADD: operands have the same sign and the result sign differs.
- ovf for SUB: operands have different signs and the result sign differs from a.
- MUL: at the accept edge, load the multiplicand, the multiplier and a counter set to WIDTH, clear the accumulator, and go IDLE -> MUL.
- Each MUL cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right and decrement the counter.
- The final iteration loads result with the low WIDTH bits (correct for signed operands) and moves to DONE. For MUL, ovf = 0 and err = 0.
- DONE: out_valid = 1. result and flags hold until out_valid && out_ready, then go DONE -> IDLE.
- No new operation is accepted in the same cycle as a DONE handshake.
- Reset value of every output: out_valid 0, result 0, zero 0, ovf 0, err 0. in_ready reads 1 during reset.
- Reset asserted mid-MUL or mid-DONE aborts the operation. Nothing is delivered afterwards.
- in_valid held high while in_ready is 0 has no effect. The source must keep it asserted until accepted.

## Timing
- Single-cycle ops: out_valid is high from the accept edge (latency 1). Maximum throughput is one operation every 2 cycles.
- MUL: out_valid rises at accept edge + WIDTH (8 cycles when WIDTH = 8).
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high.
- Outputs are purely registered. in_ready is the only combinational output and depends only on state.

## Configuration
- SEQ_ALU_MUL_EN defined: opcode 101 performs the multi-cycle MUL described above, and the MUL state, counter and accumulator are built.
- SEQ_ALU_MUL_EN undefined: no MUL logic is built. Opcode 101 is illegal, completes in 1 cycle with result 0 and err = 1, and the FSM never enters MUL.

## Structure
- Shared package seq_alu_pkg holds:
  - the opcode enum (OP_FWD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL);
  - the state enum (S_IDLE, S_MUL, S_DONE).
- One natural sub-module, seq_alu_comb: a combinational WIDTH-bit FWD/ADD/SUB/AND/OR datapath that produces result and ovf. The top holds the FSM, the multiplier and the output registers.

## Test plan
- WIDTH = 8, op AND, a = 8'hD4, b = 8'h0A -> result 8'h00, zero = 1, out_valid one edge after accept.
- ADD, a = 8'h7F, b = 8'h01 -> result 8'h80, ovf = 1. SUB, a = 8'h05, b = 8'h05 -> result 0, zero = 1, ovf = 0.
- MUL (macro on), a = 15, b = 11 -> result 8'hA5, out_valid exactly 8 edges after accept. With a = -3, b = 5 -> 8'hF1.
- out_ready held low for 3 cycles in DONE with in_valid high and new operands -> result, flags and in_ready = 0 all stable. The new operation is accepted only after the handshake and the return to IDLE.
- rst_n pulsed low 4 cycles into a MUL -> out_valid 0, result 0, in_ready 1 immediately. No result is delivered after reset is released.
- op 3'b110, or 3'b101 with the macro off -> result 0, err = 1, zero = 1, latency 1.
